// File: rtl/axi_tg_pkg.sv
// rtl/axi_tg_pkg.sv - shared types, AXI constants and helpers for the traffic generator
package axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW,
    ST_WR_D,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_D,
    ST_FIN
  } tg_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding for a full-width beat: log2 of the byte count
  function automatic logic [2:0] size_from_width(input int data_w);
    int         bytes;
    logic [2:0] sz;
    bytes = data_w / 8;
    sz    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bytes == (1 << i)) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// rtl/axi_tg_pattern.sv - address, ID and data pattern shared by write and read paths
module axi_tg_pattern
  import axi_tg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  txn_idx,
  input  logic [LEN_W-1:0]  beat_idx,
  output logic [ADDR_W-1:0] addr,
  output logic [ID_W-1:0]   id,
  output logic [DATA_W-1:0] data
);

  localparam int PROD_W = CNT_W + LEN_W + 1;
  localparam int SIZE   = int'(size_from_width(DATA_W));

  logic [PROD_W-1:0] beats_before;

  // Beats issued by all earlier transactions; address and data both advance by this count
  assign beats_before = PROD_W'(txn_idx) * PROD_W'({1'b0, burst_len} + 1'b1);

  assign addr = base_addr + (ADDR_W'(beats_before) << SIZE);
  assign id   = txn_idx[ID_W-1:0];
  assign data = seed + DATA_W'(beats_before) + DATA_W'(beat_idx);

endmodule

// File: rtl/axi_traffic_gen.sv
// rtl/axi_traffic_gen.sv - AXI4 master burst write/readback traffic generator and checker
module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic [CNT_W-1:0]    num_txn,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_count,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [ID_W-1:0]     arid,
  output logic [LEN_W-1:0]    arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [ID_W-1:0]     rid,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  tg_state_e         state, state_nxt;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [CNT_W-1:0]  num_r;
  logic [DATA_W-1:0] seed_r;
  logic [CNT_W-1:0]  txn_idx;
  logic [LEN_W-1:0]  beat_idx;
  logic [WD_W-1:0]   wd_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ID_W-1:0]   cur_id;
  logic [DATA_W-1:0] cur_data;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting, wd_expire;
  logic              last_beat, last_txn, start_ok, b_err, r_err, r_end;

  axi_tg_pattern #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) u_pattern (
    .base_addr(base_r),
    .seed     (seed_r),
    .burst_len(len_r),
    .txn_idx  (txn_idx),
    .beat_idx (beat_idx),
    .addr     (cur_addr),
    .id       (cur_id),
    .data     (cur_data)
  );

  // Valids and readies are pure state decodes, so they never depend on the slave's ready
  assign awvalid = (state == ST_WR_AW);
  assign wvalid  = (state == ST_WR_D);
  assign bready  = (state == ST_WR_B);
  assign arvalid = (state == ST_RD_AR);
  assign rready  = (state == ST_RD_D);
  assign busy    = (state != ST_IDLE);

  assign awaddr  = cur_addr;
  assign araddr  = cur_addr;
  assign awid    = cur_id;
  assign arid    = cur_id;
  assign awlen   = len_r;
  assign arlen   = len_r;
  assign awsize  = size_from_width(DATA_W);
  assign arsize  = size_from_width(DATA_W);
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign wdata   = cur_data;
  assign wstrb   = {(DATA_W/8){1'b1}};
  assign wlast   = wvalid && last_beat;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign any_hs    = aw_hs || w_hs || b_hs || ar_hs || r_hs;
  assign waiting   = awvalid || wvalid || bready || arvalid || rready;
  assign wd_expire = waiting && !any_hs && (wd_cnt == WD_W'(TIMEOUT - 1));

  assign last_beat = (beat_idx == len_r);
  assign last_txn  = (txn_idx == num_r - 1'b1);
  assign start_ok  = start && (state == ST_IDLE);
  assign b_err     = (bresp != AXI_RESP_OKAY) || (bid != cur_id);
  assign r_err     = (rdata != cur_data) || (rresp != AXI_RESP_OKAY) ||
                     (rid != cur_id) || (rlast != last_beat);
  // A burst ends on RLAST or on the expected last beat, whichever comes first
  assign r_end     = rlast || last_beat;

  // State register
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one burst outstanding, all writes before any read, watchdog overrides all
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = (num_txn == '0) ? ST_FIN : ST_WR_AW;
      ST_WR_AW: if (aw_hs) state_nxt = ST_WR_D;
      ST_WR_D:  if (w_hs && last_beat) state_nxt = ST_WR_B;
      ST_WR_B:  if (b_hs) state_nxt = last_txn ? ST_RD_AR : ST_WR_AW;
      ST_RD_AR: if (ar_hs) state_nxt = ST_RD_D;
      ST_RD_D:  if (r_hs && r_end) state_nxt = last_txn ? ST_FIN : ST_RD_AR;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (wd_expire) state_nxt = ST_FIN;
  end

  // Run parameters, burst/beat counters, watchdog, error count and final status
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      base_r    <= '0;
      len_r     <= '0;
      num_r     <= '0;
      seed_r    <= '0;
      txn_idx   <= '0;
      beat_idx  <= '0;
      wd_cnt    <= '0;
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (!waiting || any_hs) wd_cnt <= '0;
      else                    wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) timeout <= 1'b1;
      if (start_ok) begin
        base_r    <= base_addr;
        len_r     <= burst_len;
        num_r     <= num_txn;
        seed_r    <= seed;
        txn_idx   <= '0;
        beat_idx  <= '0;
        err_count <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
      end
      if (aw_hs || ar_hs) beat_idx <= '0;
      if (w_hs || r_hs)   beat_idx <= beat_idx + 1'b1;
      if (((b_hs && b_err) || (r_hs && r_err)) && (err_count != '1))
        err_count <= err_count + 1'b1;
      // Write phase wraps the burst index back to 0 for the readback phase
      if (b_hs)           txn_idx <= last_txn ? '0 : txn_idx + 1'b1;
      if (r_hs && r_end)  txn_idx <= txn_idx + 1'b1;
      if (state == ST_FIN) begin
        done <= 1'b1;
        pass <= !timeout && (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb/tb_axi_traffic_gen.sv - directed self-checking bench with a zero-wait AXI slave model
module tb_axi_traffic_gen;

  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [15:0] num_txn = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;

  int n_cmp = 0;
  int n_bad = 0;

  // slave fault configuration (written by the main sequence only)
  logic ar_en = 1'b1;
  int   bad_bresp_txn = -1;
  int   bad_rid_txn = -1;
  int   bad_rdata_txn = -1;
  int   bad_rdata_beat = -1;

  // slave state and statistics (written by the slave process only)
  logic [31:0] mem [int unsigned];
  logic [31:0] w_addr, r_addr, first_wdata, last_awaddr;
  logic [3:0]  w_id, r_id, b_id, last_arid, wstrb_and;
  logic [1:0]  b_resp;
  logic [4:0]  last_sb;
  logic [7:0]  r_len, r_beat;
  logic        b_pend, r_act;
  int          w_txn, r_txn, wr_txn, rd_txn;
  int          w_beats, r_beats, wlast_cnt, any_valid, ar_wait;

  axi_traffic_gen dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_txn(num_txn), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic slv_clear();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
    mem.delete();
    w_addr = '0; r_addr = '0; first_wdata = '0; last_awaddr = '0;
    w_id = '0; r_id = '0; b_id = '0; last_arid = '0; wstrb_and = '1;
    b_resp = '0; last_sb = '0; r_len = '0; r_beat = '0; b_pend = 1'b0; r_act = 1'b0;
    w_txn = 0; r_txn = 0; wr_txn = 0; rd_txn = 0;
    w_beats = 0; r_beats = 0; wlast_cnt = 0; any_valid = 0; ar_wait = 0;
  endtask

  // Zero-wait slave: drive this cycle's responses at the falling edge, then apply
  // the handshakes that the coming rising edge will complete.
  initial begin
    slv_clear();
    forever begin
      @(negedge clk_wr);
      if (rst_wr) slv_clear();
      else begin
        awready = 1'b1;
        wready  = 1'b1;
        arready = ar_en;
        bvalid  = b_pend;
        bid     = b_id;
        bresp   = b_resp;
        rvalid  = r_act;
        rresp   = 2'b00;
        rlast   = r_act && (r_beat == r_len);
        rid     = r_id + ((r_txn == bad_rid_txn) ? 4'd1 : 4'd0);
        rdata   = mem.exists(r_addr >> 2) ? mem[r_addr >> 2] : 32'h0;
        if ((r_txn == bad_rdata_txn) && (int'(r_beat) == bad_rdata_beat)) rdata = rdata ^ 32'h1;
        if (awvalid || wvalid || arvalid) any_valid++;
        if (arvalid) ar_wait++;

        if (awvalid && awready) begin
          w_addr = awaddr; w_id = awid; w_txn = wr_txn; wr_txn++;
          last_awaddr = awaddr; last_sb = {awsize, awburst};
        end
        if (wvalid && wready) begin
          if (w_beats == 0) first_wdata = wdata;
          mem[w_addr >> 2] = wdata;
          w_addr = w_addr + 32'd4;
          w_beats++;
          wstrb_and = wstrb_and & wstrb;
          if (wlast) begin
            wlast_cnt++;
            b_pend = 1'b1;
            b_id   = w_id;
            b_resp = (w_txn == bad_bresp_txn) ? 2'b10 : 2'b00;
          end
        end
        if (bvalid && bready) b_pend = 1'b0;
        if (rvalid && rready) begin
          r_beats++;
          if (rlast) r_act = 1'b0;
          else begin
            r_beat = r_beat + 8'd1;
            r_addr = r_addr + 32'd4;
          end
        end
        if (arvalid && arready) begin
          r_act = 1'b1; r_addr = araddr; r_id = arid; r_len = arlen; r_beat = '0;
          r_txn = rd_txn; rd_txn++; last_arid = arid;
        end
      end
    end
  end

  task automatic cfg_default();
    ar_en = 1'b1; bad_bresp_txn = -1; bad_rid_txn = -1; bad_rdata_txn = -1; bad_rdata_beat = -1;
  endtask

  task automatic do_reset();
    @(negedge clk_wr);
    rst_wr = 1'b1;
    repeat (3) @(negedge clk_wr);
    rst_wr = 1'b0;
    @(negedge clk_wr);
  endtask

  task automatic start_run(input logic [31:0] b, input logic [7:0] l,
                           input logic [15:0] n, input logic [31:0] s);
    @(negedge clk_wr);
    base_addr = b; burst_len = l; num_txn = n; seed = s; start = 1'b1;
    @(negedge clk_wr);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk_wr);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    // reset state
    cfg_default();
    do_reset();
    check("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    check("rst_status", 32'({busy, done, pass, timeout}), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);

    // clean run: 4 bursts of 4 beats
    start_run(32'h1000, 8'd3, 16'd4, 32'hABCD1234);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_awvalid", 32'(awvalid), 32'd1);
    check("t1_awaddr0", awaddr, 32'h1000);
    wait_done("t1", 500);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_wbeats", 32'(w_beats), 32'd16);
    check("t1_first_wdata", first_wdata, 32'hABCD1234);
    check("t1_wlast_cnt", 32'(wlast_cnt), 32'd4);
    check("t1_mem_t1b0", mem.exists(32'h1010 >> 2) ? mem[32'h1010 >> 2] : 32'h0, 32'hABCD1238);
    check("t1_mem_t3b3", mem.exists(32'h103C >> 2) ? mem[32'h103C >> 2] : 32'h0, 32'hABCD1243);
    check("t1_last_awaddr", last_awaddr, 32'h1030);
    check("t1_last_arid", 32'(last_arid), 32'd3);
    check("t1_rbeats", 32'(r_beats), 32'd16);
    check("t1_size_burst", 32'(last_sb), 32'h9);
    check("t1_wstrb", 32'(wstrb_and), 32'hF);

    // corrupted rdata on txn 1 beat 2
    cfg_default();
    bad_rdata_txn = 1; bad_rdata_beat = 2;
    do_reset();
    start_run(32'h2000, 8'd3, 16'd4, 32'h11111111);
    wait_done("t2", 500);
    check("t2_err", 32'(err_count), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_rbeats", 32'(r_beats), 32'd16);

    // bad bresp on txn 0 and off-by-one rid on txn 2, single-beat bursts
    cfg_default();
    bad_bresp_txn = 0; bad_rid_txn = 2;
    do_reset();
    start_run(32'h0, 8'd0, 16'd4, 32'h00000042);
    wait_done("t3", 300);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_pass", 32'(pass), 32'd0);

    // arready never asserted: watchdog aborts the read address phase
    cfg_default();
    ar_en = 1'b0;
    do_reset();
    start_run(32'h0, 8'd0, 16'd1, 32'h0);
    wait_done("t4", 1200);
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_arvalid", 32'(arvalid), 32'd0);
    check("t4_ar_wait", 32'(ar_wait), 32'd1024);
    check("t4_busy", 32'(busy), 32'd0);

    // zero transactions
    cfg_default();
    do_reset();
    start_run(32'h0, 8'd3, 16'd0, 32'h0);
    check("t5_fin_done", 32'(done), 32'd0);
    @(negedge clk_wr);
    check("t5_done", 32'(done), 32'd1);
    check("t5_pass", 32'(pass), 32'd1);
    check("t5_no_axi", 32'(any_valid), 32'd0);

    // asynchronous reset in the middle of a W burst, then a clean rerun
    cfg_default();
    do_reset();
    start_run(32'h3000, 8'd3, 16'd4, 32'h5A5A0000);
    begin
      int n = 0;
      while (!wvalid && n < 50) begin
        @(negedge clk_wr);
        n++;
      end
    end
    check("t6_wvalid_seen", 32'(wvalid), 32'd1);
    @(negedge clk_wr);
    check("t6_wvalid_mid", 32'(wvalid), 32'd1);
    #2 rst_wr = 1'b1;
    #1;
    check("t6_rst_wvalid", 32'(wvalid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wdata", wdata, 32'd0);
    repeat (2) @(negedge clk_wr);
    rst_wr = 1'b0;
    @(negedge clk_wr);
    start_run(32'h3000, 8'd1, 16'd2, 32'h5A5A0000);
    wait_done("t6", 300);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_err", 32'(err_count), 32'd0);
    check("t6_wbeats", 32'(w_beats), 32'd4);
    check("t6_first_wdata", first_wdata, 32'h5A5A0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
